mem_stage: RTL and testbench

Memory stage of the five-stage MIPS pipeline. It consumes the EX/MEM register outputs, drives a handshaked data-memory port for `lw`/`sw`, and computes the branch decision. It also owns the MEM/WB pipeline register feeding write-back. A slow data memory stalls the upstream stages through `stall`, and bubbles are inserted into MEM/WB while an access is outstanding.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/mem_stage_if.sv | 29 ++
 rtl/mem_wb.sv | 48 ++++
 rtl/mem_stage.sv | 142 ++++++++++++++
 tb/tb_mem_stage.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS pipeline memory stage:
//   - wb_ctl bit positions ({regwrite, memtoreg})
//   - the MEM/WB bubble control value
//   - the MEM-stage FSM state encoding (legacy-compatible constants)
// ---------------------------------------------------------------------------
package mips_pkg;

  // wb_ctl = {regwrite, memtoreg}
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // A bubble writes nothing back and does not select memory data.
  localparam logic [1:0] WB_BUBBLE = 2'b00;

  // MEM-stage FSM
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if
// Handshaked data-memory port between the MEM stage and the data memory.
//   dmem_req    request valid (held until the access completes)
//   dmem_we     write enable (store when 1, load when 0)
//   dmem_addr   word address
//   dmem_wdata  store data
//   dmem_ready  access complete, only meaningful while dmem_req = 1
//   dmem_rdata  load data, valid together with dmem_ready
// Modports: master = MEM stage, slave = memory.
// ---------------------------------------------------------------------------
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_wb.sv
// ---------------------------------------------------------------------------
// mem_wb
// MEM/WB pipeline register.
//   clk, reset        rising-edge clock, async active-low reset (clears all)
//   bubble            1: load a bubble (ctl = 00, data fields hold)
//   *_in              values captured when bubble = 0
//   mem_wb_ctl        {regwrite, memtoreg}
//   mem_read_data     load data (0 for non-loads)
//   mem_alu_result    ALU result
//   mem_write_reg     destination register
// ---------------------------------------------------------------------------
module mem_wb
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        bubble,
  input  logic [1:0]  wb_ctl_in,
  input  logic [31:0] read_data_in,
  input  logic [31:0] alu_result_in,
  input  logic [4:0]  write_reg_in,
  output logic [1:0]  mem_wb_ctl,
  output logic [31:0] mem_read_data,
  output logic [31:0] mem_alu_result,
  output logic [4:0]  mem_write_reg
);

  // NOTE: sequential state is written with <= so every register samples
  // pre-edge values; blocking assignments here would create order-dependent
  // simulation that no longer matches the synthesized flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_wb_ctl     <= WB_BUBBLE;
      mem_read_data  <= '0;
      mem_alu_result <= '0;
      mem_write_reg  <= '0;
    end else if (bubble) begin
      // Only the control is squashed; data fields keep their old value.
      mem_wb_ctl     <= WB_BUBBLE;
    end else begin
      mem_wb_ctl     <= wb_ctl_in;
      mem_read_data  <= read_data_in;
      mem_alu_result <= alu_result_in;
      mem_write_reg  <= write_reg_in;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory stage of the five-stage MIPS pipeline.
//   clk, reset         rising-edge clock, async active-low reset
//   wb_ctl, branch, memread, memwrite, EX_MEM_NPC, zero, alu_result,
//   rdata2out, five_bit_muxout   EX/MEM register outputs
//   pcsrc, branch_target         branch decision (combinational)
//   stall              freeze upstream stages this cycle
//   dmem               handshaked data-memory port (master side)
//   mem_wb_ctl, mem_read_data, mem_alu_result, mem_write_reg   MEM/WB
//   err_align, err_timeout, err_ctl   sticky error flags
// A legal lw/sw spends one IDLE cycle issuing the request, then one or more
// BUSY cycles waiting for dmem_ready. Accesses that never complete are
// aborted after MAX_WAIT BUSY cycles and retire as a bubble.
// ---------------------------------------------------------------------------
module mem_stage
  import mips_pkg::*;
#(
  parameter int          MAX_WAIT     = 16,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         wb_ctl,
  input  logic               branch,
  input  logic               memread,
  input  logic               memwrite,
  input  logic [31:0]        EX_MEM_NPC,
  input  logic               zero,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        rdata2out,
  input  logic [4:0]         five_bit_muxout,
  output logic               pcsrc,
  output logic [31:0]        branch_target,
  output logic               stall,
  mem_stage_if.master        dmem,
  output logic [1:0]         mem_wb_ctl,
  output logic [31:0]        mem_read_data,
  output logic [31:0]        mem_alu_result,
  output logic [4:0]         mem_write_reg,
  output logic               err_align,
  output logic               err_timeout,
  output logic               err_ctl
);

  localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  // Aborted loads retire as a bubble, so the timeout fill value is never used.
  logic [31:0] unused_timeout_data;
  assign unused_timeout_data = TIMEOUT_DATA;

  logic [0:0]       state_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             req_q, we_q;
  logic [31:0]      addr_q, wdata_q;

  logic access, misaligned, conflict, ok;
  logic busy, done, at_last, bubble;
  logic [31:0] read_data_in;

  assign pcsrc         = branch & zero;
  assign branch_target = EX_MEM_NPC;

  assign access     = memread | memwrite;
  assign misaligned = alu_result[1:0] != 2'b00;
  assign conflict   = memread & memwrite;
  assign ok         = access & ~misaligned & ~conflict;

  assign busy    = (state_q == ST_BUSY);
  assign done    = busy & dmem.dmem_ready;
  assign at_last = (wait_cnt == CNT_LAST);

  // Built only from state, ok and ready so there is no path from dmem_rdata.
  assign stall = busy ? (~dmem.dmem_ready & ~at_last) : ok;

  // IDLE: any memory instruction leaves a bubble (issued or rejected).
  // BUSY: only a completed access writes real values.
  assign bubble       = busy ? ~done : access;
  assign read_data_in = (busy && !we_q) ? dmem.dmem_rdata : 32'h0;

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wait_cnt    <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_align   <= 1'b0;
      err_timeout <= 1'b0;
      err_ctl     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ok) begin
            // Port registers are frozen from here until the access ends.
            req_q    <= 1'b1;
            we_q     <= memwrite;
            addr_q   <= alu_result;
            wdata_q  <= rdata2out;
            wait_cnt <= '0;
            state_q  <= ST_BUSY;
          end else if (access) begin
            if (misaligned) err_align <= 1'b1;
            if (conflict)   err_ctl   <= 1'b1;
          end
        end
        default: begin
          if (dmem.dmem_ready || at_last) begin
            if (!dmem.dmem_ready) err_timeout <= 1'b1;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  mem_wb u_mem_wb (
    .clk            (clk),
    .reset          (reset),
    .bubble         (bubble),
    .wb_ctl_in      (wb_ctl),
    .read_data_in   (read_data_in),
    .alu_result_in  (alu_result),
    .write_reg_in   (five_bit_muxout),
    .mem_wb_ctl     (mem_wb_ctl),
    .mem_read_data  (mem_read_data),
    .mem_alu_result (mem_alu_result),
    .mem_write_reg  (mem_write_reg)
  );

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Directed self-checking bench for mem_stage (MAX_WAIT = 16).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge or 1 ns after the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wb_ctl;
  logic        branch, memread, memwrite, zero;
  logic [31:0] EX_MEM_NPC, alu_result, rdata2out;
  logic [4:0]  five_bit_muxout;
  logic        pcsrc, stall;
  logic [31:0] branch_target;
  logic [1:0]  mem_wb_ctl;
  logic [31:0] mem_read_data, mem_alu_result;
  logic [4:0]  mem_write_reg;
  logic        err_align, err_timeout, err_ctl;

  mem_stage_if dmem ();

  always #5 clk = ~clk;

  mem_stage #(.MAX_WAIT(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .wb_ctl          (wb_ctl),
    .branch          (branch),
    .memread         (memread),
    .memwrite        (memwrite),
    .EX_MEM_NPC      (EX_MEM_NPC),
    .zero            (zero),
    .alu_result      (alu_result),
    .rdata2out       (rdata2out),
    .five_bit_muxout (five_bit_muxout),
    .pcsrc           (pcsrc),
    .branch_target   (branch_target),
    .stall           (stall),
    .dmem            (dmem),
    .mem_wb_ctl      (mem_wb_ctl),
    .mem_read_data   (mem_read_data),
    .mem_alu_result  (mem_alu_result),
    .mem_write_reg   (mem_write_reg),
    .err_align       (err_align),
    .err_timeout     (err_timeout),
    .err_ctl         (err_ctl)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Per-access observations collected by run_access.
  int stall_n, req_n, we_n, addr_bad, wdata_bad, wbctl_bad;
  bit done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic [1:0] ctl, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] dst);
    wb_ctl          = ctl;
    branch          = 1'b0;
    zero            = 1'b0;
    EX_MEM_NPC      = 32'h0;
    memread         = rd;
    memwrite        = wr;
    alu_result      = addr;
    rdata2out       = wdata;
    five_bit_muxout = dst;
  endtask

  // Holds the current instruction until dmem_req is low after an edge.
  // Cycle 0 is the IDLE cycle; ready is raised on cycle ready_cycle
  // (never when negative) and optionally during the IDLE cycle.
  task automatic run_access(input int ready_cycle, input bit ready_idle,
                            input logic [31:0] rdata, input logic [31:0] exp_addr,
                            input logic [31:0] exp_wdata);
    stall_n = 0; req_n = 0; we_n = 0; addr_bad = 0; wdata_bad = 0; wbctl_bad = 0;
    done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      dmem.dmem_ready = (c == ready_cycle) || (ready_idle && c == 0);
      dmem.dmem_rdata = (c == ready_cycle) ? rdata : 32'hFFFF_FFFF;
      @(negedge clk);
      if (stall) stall_n++;
      if (dmem.dmem_req) begin
        req_n++;
        if (dmem.dmem_we) we_n++;
        if (dmem.dmem_addr !== exp_addr) addr_bad++;
        if (dmem.dmem_wdata !== exp_wdata) wdata_bad++;
      end
      if (c > 0 && mem_wb_ctl !== 2'b00) wbctl_bad++;
      @(posedge clk); #1;
      if (!dmem.dmem_req) begin
        done = 1'b1;
        break;
      end
    end
    dmem.dmem_ready = 1'b0;
    dmem.dmem_rdata = 32'h0;
    check("access_terminates", 32'(done), 32'h1);
  endtask

  initial begin
    reset = 1'b0;
    set_instr(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    dmem.dmem_ready = 1'b0;
    dmem.dmem_rdata = 32'h0;

    // Reset state
    @(negedge clk);
    check("rst_mem_wb_ctl", 32'(mem_wb_ctl), 32'h0);
    check("rst_mem_alu_result", mem_alu_result, 32'h0);
    check("rst_dmem_req", 32'(dmem.dmem_req), 32'h0);
    check("rst_dmem_addr", dmem.dmem_addr, 32'h0);
    check("rst_errs", {29'h0, err_align, err_timeout, err_ctl}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // add: one-cycle pass-through, no stall
    set_instr(2'b10, 1'b0, 1'b0, 32'h5, 32'h0, 5'd3);
    @(negedge clk);
    check("add_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    check("add_wb_ctl", 32'(mem_wb_ctl), 32'h2);
    check("add_alu_result", mem_alu_result, 32'h5);
    check("add_write_reg", 32'(mem_write_reg), 32'h3);
    check("add_read_data", mem_read_data, 32'h0);

    // beq: combinational branch decision
    set_instr(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    branch = 1'b1; zero = 1'b1; EX_MEM_NPC = 32'h100;
    @(negedge clk);
    check("beq_pcsrc_taken", 32'(pcsrc), 32'h1);
    check("beq_target", branch_target, 32'h100);
    check("beq_no_req", 32'(dmem.dmem_req), 32'h0);
    zero = 1'b0;
    #1;
    check("beq_pcsrc_not_taken", 32'(pcsrc), 32'h0);
    @(posedge clk); #1;

    // lw 0x40, ready on the 4th BUSY cycle
    set_instr(2'b11, 1'b1, 1'b0, 32'h40, 32'h0, 5'd7);
    run_access(4, 1'b0, 32'h1234, 32'h40, 32'h0);
    check("lw_stall_cycles", 32'(stall_n), 32'd4);
    check("lw_req_cycles", 32'(req_n), 32'd4);
    check("lw_we_cycles", 32'(we_n), 32'd0);
    check("lw_addr_unstable", 32'(addr_bad), 32'd0);
    check("lw_bubbles", 32'(wbctl_bad), 32'd0);
    check("lw_read_data", mem_read_data, 32'h1234);
    check("lw_wb_ctl", 32'(mem_wb_ctl), 32'h3);
    check("lw_alu_result", mem_alu_result, 32'h40);
    check("lw_write_reg", 32'(mem_write_reg), 32'h7);

    // sw 0x8, ready already during IDLE (ignored) and in the first BUSY cycle
    set_instr(2'b00, 1'b0, 1'b1, 32'h8, 32'hA5A5, 5'd9);
    run_access(1, 1'b1, 32'h0, 32'h8, 32'hA5A5);
    check("sw_stall_cycles", 32'(stall_n), 32'd1);
    check("sw_req_cycles", 32'(req_n), 32'd1);
    check("sw_we_cycles", 32'(we_n), 32'd1);
    check("sw_wdata_unstable", 32'(wdata_bad), 32'd0);
    check("sw_we_after", 32'(dmem.dmem_we), 32'h0);
    check("sw_wb_ctl", 32'(mem_wb_ctl), 32'h0);
    check("sw_read_data", mem_read_data, 32'h0);
    check("sw_alu_result", mem_alu_result, 32'h8);

    // misaligned lw 0x42: rejected, bubble, no stall
    set_instr(2'b11, 1'b1, 1'b0, 32'h42, 32'h0, 5'd5);
    run_access(-1, 1'b0, 32'h0, 32'h42, 32'h0);
    check("align_stall_cycles", 32'(stall_n), 32'd0);
    check("align_req_cycles", 32'(req_n), 32'd0);
    check("align_err_align", 32'(err_align), 32'h1);
    check("align_err_ctl", 32'(err_ctl), 32'h0);
    check("align_wb_ctl", 32'(mem_wb_ctl), 32'h0);
    check("align_alu_hold", mem_alu_result, 32'h8);

    // memread and memwrite both set: rejected
    set_instr(2'b11, 1'b1, 1'b1, 32'h10, 32'h0, 5'd6);
    run_access(-1, 1'b0, 32'h0, 32'h10, 32'h0);
    check("ctl_stall_cycles", 32'(stall_n), 32'd0);
    check("ctl_req_cycles", 32'(req_n), 32'd0);
    check("ctl_err_ctl", 32'(err_ctl), 32'h1);
    check("ctl_wb_ctl", 32'(mem_wb_ctl), 32'h0);

    // lw that never completes: aborted on the 16th BUSY cycle
    set_instr(2'b11, 1'b1, 1'b0, 32'h20, 32'h0, 5'd4);
    run_access(-1, 1'b0, 32'h0, 32'h20, 32'h0);
    check("to_stall_cycles", 32'(stall_n), 32'd16);
    check("to_req_cycles", 32'(req_n), 32'd16);
    check("to_err_timeout", 32'(err_timeout), 32'h1);
    check("to_dmem_req", 32'(dmem.dmem_req), 32'h0);
    check("to_wb_ctl", 32'(mem_wb_ctl), 32'h0);
    check("to_alu_hold", mem_alu_result, 32'h8);

    // reset pulsed mid-BUSY
    set_instr(2'b11, 1'b1, 1'b0, 32'h30, 32'h0, 5'd2);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("rst2_req_before", 32'(dmem.dmem_req), 32'h1);
    #2;
    reset = 1'b0;
    set_instr(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    check("rst2_dmem_req", 32'(dmem.dmem_req), 32'h0);
    check("rst2_dmem_addr", dmem.dmem_addr, 32'h0);
    check("rst2_mem_wb_ctl", 32'(mem_wb_ctl), 32'h0);
    check("rst2_mem_alu_result", mem_alu_result, 32'h0);
    check("rst2_errs", {29'h0, err_align, err_timeout, err_ctl}, 32'h0);
    check("rst2_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // back in IDLE: a plain instruction passes straight through
    set_instr(2'b10, 1'b0, 1'b0, 32'h77, 32'h0, 5'd1);
    @(posedge clk); #1;
    check("post_rst_wb_ctl", 32'(mem_wb_ctl), 32'h2);
    check("post_rst_alu_result", mem_alu_result, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
